// File: rtl/axis_i2c_pkg.sv
// axis_i2c_pkg: shared AXIS width, arbiter defaults, arbiter state type and a minimum-1 clog2 helper
package axis_i2c_pkg;
  localparam int AXIS_DATA_WIDTH = 8;
  localparam int ARB_N_REQ = 3;
  localparam int ARB_TXN_BEATS = 3;
  localparam int ARB_TIMEOUT = 255;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axis_if.sv
// axis_if: AXI-Stream bundle (tdata/tvalid/tready) with master and slave views
interface axis_if #(parameter int W = axis_i2c_pkg::AXIS_DATA_WIDTH);
  logic [W-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master(output tdata, output tvalid, input tready);
  modport slave(input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_i2c_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick (req, last in; gnt_idx, gnt_valid out), searching upward from last+1 with wrap
module rr_arbiter
  import axis_i2c_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ
) (
  input  logic [N_REQ-1:0]     req,
  input  logic [cw(N_REQ)-1:0] last,
  output logic [cw(N_REQ)-1:0] gnt_idx,
  output logic                 gnt_valid
);
  localparam int LW = cw(N_REQ);
  logic [LW-1:0] i;
  always_comb begin
    gnt_idx = '0;
    gnt_valid = |req;
    i = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      i = LW'((int'(last) + k) % N_REQ);
      if (req[i]) gnt_idx = i;
    end
  end
endmodule

// File: rtl/axis_i2c_arbiter.sv
// axis_i2c_arbiter: round-robin share of one AXIS command stream (clk_i, arstn_i; s_tdata/s_tvalid/s_tready requesters; m_axis out; grant_o/busy_o/timeout_o status) holding each grant for TXN_BEATS beats with an owner-stall watchdog
module axis_i2c_arbiter
  import axis_i2c_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ,
  parameter int TXN_BEATS = ARB_TXN_BEATS,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                                  clk_i,
  input  logic                                  arstn_i,
  input  logic [N_REQ-1:0][AXIS_DATA_WIDTH-1:0] s_tdata,
  input  logic [N_REQ-1:0]                      s_tvalid,
  output logic [N_REQ-1:0]                      s_tready,
  axis_if.master                                m_axis,
  output logic [N_REQ-1:0]                      grant_o,
  output logic                                  busy_o,
  output logic                                  timeout_o
);
  localparam int LW = cw(N_REQ);
  localparam int BW = cw(TXN_BEATS);
  localparam int WW = cw(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(TXN_BEATS - 1);
  localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  arb_state_t state_q, state_d;
  logic [LW-1:0] grant_q, grant_d, last_q, last_d, gnt_idx;
  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wd_q, wd_d;
  logic tout_q, tout_d, gnt_valid, own_v;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req(s_tvalid),
    .last(last_q),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid)
  );
  assign busy_o = state_q == ARB_BURST;
  assign grant_o = busy_o ? N_REQ'(1) << grant_q : '0;
  assign timeout_o = tout_q;
  assign own_v = s_tvalid[grant_q];
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    beat_d = beat_q;
    wd_d = wd_q;
    tout_d = 1'b0;
    s_tready = '0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata = '0;
    if (state_q == ARB_IDLE) begin
      if (gnt_valid) begin
        state_d = ARB_BURST;
        grant_d = gnt_idx;
        beat_d = '0;
        wd_d = '0;
      end
    end else begin
      m_axis.tdata = s_tdata[grant_q];
      m_axis.tvalid = own_v;
      s_tready[grant_q] = m_axis.tready;
      beat_d = own_v && m_axis.tready ? beat_q + 1'b1 : beat_q;
      wd_d = own_v ? '0 : wd_q == '1 ? wd_q : wd_q + 1'b1;
      if (own_v && m_axis.tready && beat_q == LAST_BEAT) begin
        state_d = ARB_IDLE;
        last_d = grant_q;
      end
      if (TIMEOUT > 0 && !own_v && wd_q == WD_LIM) begin
        state_d = ARB_IDLE;
        last_d = grant_q;
        tout_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q <= LW'(N_REQ - 1);
      beat_q <= '0;
      wd_q <= '0;
      tout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      beat_q <= beat_d;
      wd_q <= wd_d;
      tout_q <= tout_d;
    end
  end
endmodule
